io_out_uart_tx: RTL and testbench
=================================

Name: io_out_uart_tx

Overview:
- Consumer end of the OUT path. Takes the `out_req`/`out_data` pulses raised when a store hits `IO_FILE_POINTER`.
- Buffers them in a word FIFO and serializes them as 8N1 UART frames on `txd`.
- Sits between the memory-access/IO stage and the board pin. Provides backpressure (`full`) and a sticky overflow flag.

Parameters:
- `CLK_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, 16: word entries; power of two, ≥ 2.
- `BYTES_PER_WORD`, 1: bytes sent per word, 1..4. Sent little-endian, starting at `out_data[7:0]`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `out_req`  in  1  single-cycle push strobe from the IO stage
- `out_data`  in  32  word to transmit; sampled when `out_req`=1
- `full`  out  1  FIFO holds `FIFO_DEPTH` words; registered
- `overflow`  out  1  sticky: a push was dropped
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `txd`  out  1  UART serial output; idle high

Behaviour:
- Reset (async, active-high): FIFO empty, `full`=0, `overflow`=0, `busy`=0, `txd`=1, FSM=IDLE, baud counter=0, byte index=0.
- Reset asserted mid-frame: `txd` goes to 1 immediately and the frame is abandoned. All buffered words are lost.
- Push:
  - On a rising edge with `out_req`=1 and count<`FIFO_DEPTH`, write `out_data` at the write pointer; wptr+1 mod `FIFO_DEPTH`.
  - If count==`FIFO_DEPTH`, the word is dropped and `overflow`←1. This holds even if a pop happens the same cycle; `full` is judged on pre-edge count.
  - `overflow` clears only on `rst`.
- Pop: only the FSM pops, in IDLE when count>0. Read data is latched into the shift word; rptr+1.
- Push and pop in the same edge: count unchanged, both pointers advance.
- `full` = (next count == `FIFO_DEPTH`), registered. `busy` = (count≠0) | (state≠IDLE), registered.
- FSM states IDLE, START, DATA, STOP. Baud counter `bc` counts 0..`CLK_PER_BIT`-1; a bit boundary is `bc`==`CLK_PER_BIT`-1.
  - IDLE: `txd`=1. If count>0: pop, byte_idx←0, `bc`←0, go to START.
  - START: `txd`=0 for `CLK_PER_BIT` cycles, then DATA with bit_idx←0.
  - DATA: `txd` = current byte[bit_idx], LSB first, each bit held `CLK_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `txd`=1 for `CLK_PER_BIT` cycles. Then, if byte_idx<`BYTES_PER_WORD`-1: byte_idx+1 and go to START. Otherwise go to IDLE.
- Current byte = shift_word[8*byte_idx +: 8].
- `txd` is driven from a flop (glitch-free).
- Latency: `out_req` accepted at edge E0 into an empty FIFO with FSM IDLE → pop at E1 → `txd` falls after E2 and stays low `CLK_PER_BIT` cycles.
- Back-to-back words: IDLE lasts exactly one cycle between STOP end and the next START (one extra idle-high cycle).
- Frame length: 10·`CLK_PER_BIT` cycles per byte; one word takes 10·`CLK_PER_BIT`·`BYTES_PER_WORD` + 1 cycles.
- Pointer wrap: pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. Count is log2(`FIFO_DEPTH`)+1 bits.
- `out_data` bits above 8·`BYTES_PER_WORD` are ignored.

Test Plan:
- `CLK_PER_BIT`=4, `BYTES_PER_WORD`=1. Single `out_req` with `out_data`=0x00000041 → `txd` low from 2 edges later for 4 cycles, then bits 1,0,0,0,0,0,1,0 (4 cycles each), then high 4 cycles. `busy` drops 1 cycle after STOP.
- `BYTES_PER_WORD`=4, `out_data`=0x44332211 → four frames in order 0x11, 0x22, 0x33, 0x44, with no IDLE gap between bytes.
- `FIFO_DEPTH`=4. Push 6 words on consecutive cycles while FSM busy → 1st popped immediately, next 4 stored. 6th dropped: `full`=1 and `overflow`=1 after that edge; emitted sequence is words 1–5.
- Push exactly at the cycle of an IDLE pop with count=`FIFO_DEPTH` → push dropped, `overflow`=1, count stays `FIFO_DEPTH`-1 after the edge.
- Wrap: push/drain 3×`FIFO_DEPTH` words with random gaps → byte stream matches push order exactly; `overflow` stays 0.
- Assert `rst` mid-DATA of 0x55 → `txd`=1 asynchronously, `busy`=0, FIFO empty. After release, new word 0x0F transmits cleanly.

Source files
------------

// File: rtl/io_out_uart_tx.sv
// rtl/io_out_uart_tx.sv - word FIFO feeding an 8N1 UART transmitter for the OUT path
module io_out_uart_tx #(
    parameter int CLK_PER_BIT    = 868,
    parameter int FIFO_DEPTH     = 16,
    parameter int BYTES_PER_WORD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_req,
    input  logic [31:0] out_data,
    output logic        full,
    output logic        overflow,
    output logic        busy,
    output logic        txd
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BCW = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(CLK_PER_BIT - 1);
    localparam logic [1:0]     LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    // Bytes beyond BYTES_PER_WORD are never sent; clear them on entry
    localparam logic [31:0]    DATA_MASK = (BYTES_PER_WORD >= 4) ? 32'hFFFF_FFFF
                                         : ((32'd1 << (8 * BYTES_PER_WORD)) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [31:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    state_t         state;
    logic [BCW-1:0] bc;
    logic [2:0]     bit_idx;
    logic [1:0]     byte_idx;
    logic [31:0]    shift_word;
    logic [7:0]     cur_byte;
    logic           push_ok;
    logic           pop;
    logic           bc_last;

    // Push/pop decisions use the pre-edge count, so a push into a full FIFO drops even on a pop cycle
    always_comb begin
        push_ok  = out_req && (count != DEPTH_C);
        pop      = (state == S_IDLE) && (count != '0);
        bc_last  = (bc == BC_LAST);
        cur_byte = shift_word[{byte_idx, 3'b000} +: 8];
        case ({push_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= out_data & DATA_MASK;
        end
    end

    // FIFO pointers, occupancy, full and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (out_req && !push_ok) begin
                overflow <= 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
        end
    end

    // Busy reflects buffered words or a frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (count != '0) || (state != S_IDLE);
        end
    end

    // Frame sequencer; txd is a flop decoded from the current state, one cycle behind it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bc         <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift_word <= '0;
            txd        <= 1'b1;
        end else begin
            case (state)
                S_IDLE:  txd <= 1'b1;
                S_START: txd <= 1'b0;
                S_DATA:  txd <= cur_byte[bit_idx];
                default: txd <= 1'b1;
            endcase

            case (state)
                S_IDLE: begin
                    bc <= '0;
                    if (pop) begin
                        shift_word <= mem[rptr];
                        byte_idx   <= '0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (bc_last) begin
                        bc      <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        bc <= bc + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bc_last) begin
                        bc <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bc <= bc + 1'b1;
                    end
                end
                default: begin
                    if (bc_last) begin
                        bc <= '0;
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bc <= bc + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_out_uart_tx.sv
// tb/tb_io_out_uart_tx.sv - self-checking bench for io_out_uart_tx
module tb_io_out_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req4;
    logic [31:0] data1, data4;
    logic        full1, overflow1, busy1, txd1;
    logic        full4, overflow4, busy4, txd4;
    logic        mon_en1, mon_en4;

    int checks = 0;
    int errors = 0;

    logic [7:0] q1[$];
    logic [7:0] q4[$];

    typedef struct {
        logic [31:0] data;
        logic        exp_full;
        logic        exp_ovf;
        bit          accept;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    io_out_uart_tx #(.CLK_PER_BIT(4), .FIFO_DEPTH(4), .BYTES_PER_WORD(1)) dut1 (
        .clk(clk), .rst(rst), .out_req(req1), .out_data(data1),
        .full(full1), .overflow(overflow1), .busy(busy1), .txd(txd1)
    );

    io_out_uart_tx #(.CLK_PER_BIT(4), .FIFO_DEPTH(4), .BYTES_PER_WORD(4)) dut4 (
        .clk(clk), .rst(rst), .out_req(req4), .out_data(data4),
        .full(full4), .overflow(overflow4), .busy(busy4), .txd(txd4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic uart_rx(input int which, output logic [7:0] b, output logic stop_bit);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = (which == 4) ? txd4 : txd1;
        end
        repeat (4) @(negedge clk);
        stop_bit = (which == 4) ? txd4 : txd1;
    endtask

    initial begin : mon_1
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        logic       sb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en1 && prev && txd1 === 1'b0) begin
                repeat (2) @(negedge clk);
                chk("mon1_start", {31'd0, txd1}, 32'd0);
                uart_rx(1, b, sb);
                chk("mon1_stop", {31'd0, sb}, 32'd1);
                if (mon_en1) begin
                    if (q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon1_extra: got byte 0x%0h, expected none", b);
                    end else begin
                        e = q1.pop_front();
                        chk("mon1_byte", {24'd0, b}, {24'd0, e});
                    end
                end
                prev = 1'b1;
            end else begin
                prev = txd1;
            end
        end
    end

    initial begin : mon_4
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        logic       sb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en4 && prev && txd4 === 1'b0) begin
                repeat (2) @(negedge clk);
                chk("mon4_start", {31'd0, txd4}, 32'd0);
                uart_rx(4, b, sb);
                chk("mon4_stop", {31'd0, sb}, 32'd1);
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon4_extra: got byte 0x%0h, expected none", b);
                end else begin
                    e = q4.pop_front();
                    chk("mon4_byte", {24'd0, b}, {24'd0, e});
                end
                prev = 1'b1;
            end else begin
                prev = txd4;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy1 || busy4 || q1.size() != 0 || q4.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("idle_busy1", {31'd0, busy1}, 32'd0);
        chk("idle_busy4", {31'd0, busy4}, 32'd0);
        chk("idle_q1", 32'(q1.size()), 32'd0);
        chk("idle_q4", 32'(q4.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] frame41;
        logic       exp_txd;
        int         p;
        int         gap;
        int         n;

        rst     = 1'b1;
        req1    = 1'b0;
        req4    = 1'b0;
        data1   = '0;
        data4   = '0;
        mon_en1 = 1'b1;
        mon_en4 = 1'b1;

        #1;
        chk("rst_txd1", {31'd0, txd1}, 32'd1);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_full1", {31'd0, full1}, 32'd0);
        chk("rst_ovf1", {31'd0, overflow1}, 32'd0);
        chk("rst_txd4", {31'd0, txd4}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 0x41: exact waveform and busy timing
        frame41 = 8'h41;
        req1  = 1'b1;
        data1 = 32'h0000_0041;
        q1.push_back(8'h41);
        @(posedge clk);
        #1 req1 = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            @(posedge clk);
            #1;
            p = (c - 2) / 4;
            if (c < 2)       exp_txd = 1'b1;
            else if (p == 0) exp_txd = 1'b0;
            else if (p <= 8) exp_txd = frame41[p-1];
            else             exp_txd = 1'b1;
            chk($sformatf("t1_txd_e%0d", c), {31'd0, txd1}, {31'd0, exp_txd});
            if (c == 1 || c == 41) chk($sformatf("t1_busy_e%0d", c), {31'd0, busy1}, 32'd1);
            if (c == 42)           chk("t1_busy_drop", {31'd0, busy1}, 32'd0);
        end
        wait_idle();

        // Four bytes per word, no idle gap between bytes of one word
        @(negedge clk);
        req4  = 1'b1;
        data4 = 32'h4433_2211;
        q4.push_back(8'h11);
        q4.push_back(8'h22);
        q4.push_back(8'h33);
        q4.push_back(8'h44);
        @(posedge clk);
        #1 req4 = 1'b0;
        for (int c = 1; c <= 162; c++) begin
            @(posedge clk);
            #1;
            if (c >= 2 && c <= 122 && (c - 2) % 40 == 0)
                chk($sformatf("w4_start_e%0d", c), {31'd0, txd4}, 32'd0);
            if (c >= 41 && c <= 121 && (c - 1) % 40 == 0)
                chk($sformatf("w4_stop_e%0d", c), {31'd0, txd4}, 32'd1);
            if (c == 161) chk("w4_busy_hold", {31'd0, busy4}, 32'd1);
            if (c == 162) chk("w4_busy_drop", {31'd0, busy4}, 32'd0);
        end
        wait_idle();

        // Overflow: six back-to-back pushes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            vecs[i].data     = 32'hCAFE_0010 + 32'(i);
            vecs[i].exp_full = (i >= 4);
            vecs[i].exp_ovf  = (i == 5);
            vecs[i].accept   = (i < 5);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req1  = 1'b1;
            data1 = vecs[i].data;
            if (vecs[i].accept) q1.push_back(vecs[i].data[7:0]);
            @(posedge clk);
            #1;
            chk($sformatf("ovf_full_%0d", i), {31'd0, full1}, {31'd0, vecs[i].exp_full});
            chk($sformatf("ovf_flag_%0d", i), {31'd0, overflow1}, {31'd0, vecs[i].exp_ovf});
        end
        @(negedge clk);
        req1 = 1'b0;
        wait_idle();
        chk("ovf_sticky", {31'd0, overflow1}, 32'd1);

        // Push coinciding with the IDLE pop while the FIFO is full
        do_reset();
        chk("coll_ovf_cleared", {31'd0, overflow1}, 32'd0);
        for (int c = 0; c <= 42; c++) begin
            @(negedge clk);
            req1  = (c <= 4) || (c == 42);
            data1 = 32'h0000_00A0 + 32'(c);
            if (c <= 4) q1.push_back(data1[7:0]);
            @(posedge clk);
            #1;
            if (c == 41) begin
                chk("coll_full_before", {31'd0, full1}, 32'd1);
                chk("coll_ovf_before", {31'd0, overflow1}, 32'd0);
            end
            if (c == 42) begin
                chk("coll_full_after", {31'd0, full1}, 32'd0);
                chk("coll_ovf_after", {31'd0, overflow1}, 32'd1);
            end
        end
        @(negedge clk);
        req1 = 1'b0;
        wait_idle();

        // Pointer wrap: 3x depth words with random gaps, respecting backpressure
        do_reset();
        for (int i = 0; i < 12; i++) begin
            gap = $urandom_range(0, 50);
            repeat (gap) @(negedge clk);
            n = 0;
            while (full1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            req1  = 1'b1;
            data1 = $urandom;
            q1.push_back(data1[7:0]);
            @(posedge clk);
            #1 req1 = 1'b0;
        end
        wait_idle();
        chk("wrap_ovf", {31'd0, overflow1}, 32'd0);

        // Reset in the middle of a frame carrying 0x55
        mon_en1 = 1'b0;
        @(negedge clk);
        req1  = 1'b1;
        data1 = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_txd_pre", {31'd0, txd1}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_txd_async", {31'd0, txd1}, 32'd1);
        chk("mid_busy_async", {31'd0, busy1}, 32'd0);
        chk("mid_full_async", {31'd0, full1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_after", {31'd0, busy1}, 32'd0);
        chk("mid_txd_after", {31'd0, txd1}, 32'd1);
        repeat (40) @(negedge clk);
        mon_en1 = 1'b1;
        @(negedge clk);
        req1  = 1'b1;
        data1 = 32'h0000_000F;
        q1.push_back(8'h0F);
        @(posedge clk);
        #1 req1 = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
